// File: rtl/issue_read_stage.sv
// Issue/register-read pipeline: stage A holds issued tags, stage B holds resolved operands.
// Source values come from the PRF read ports, with a same-cycle writeback bypass.
module issue_read_stage #(
  parameter int PREG_W = 7,
  parameter int XLEN   = 32,
  parameter int UOP_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              recover_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [PREG_W-1:0] in_pd_tag_i,
  input  logic [PREG_W-1:0] in_ps1_tag_i,
  input  logic [PREG_W-1:0] in_ps2_tag_i,
  input  logic [UOP_W-1:0]  in_uop_i,
  output logic [PREG_W-1:0] prf_rd1_addr_o,
  input  logic [XLEN-1:0]   prf_rd1_data_i,
  output logic [PREG_W-1:0] prf_rd2_addr_o,
  input  logic [XLEN-1:0]   prf_rd2_data_i,
  input  logic              wb_valid_i,
  input  logic [PREG_W-1:0] wb_tag_i,
  input  logic [XLEN-1:0]   wb_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [PREG_W-1:0] out_pd_tag_o,
  output logic [XLEN-1:0]   out_rs1_val_o,
  output logic [XLEN-1:0]   out_rs2_val_o,
  output logic [UOP_W-1:0]  out_uop_o,
  output logic [15:0]       stall_cnt_o
);

  logic              a_valid_q, a_valid_d;
  logic [PREG_W-1:0] a_pd_q, a_pd_d, a_ps1_q, a_ps1_d, a_ps2_q, a_ps2_d;
  logic [UOP_W-1:0]  a_uop_q, a_uop_d;
  logic              b_valid_q, b_valid_d;
  logic [PREG_W-1:0] b_pd_q, b_pd_d;
  logic [XLEN-1:0]   b_rs1_q, b_rs1_d, b_rs2_q, b_rs2_d;
  logic [UOP_W-1:0]  b_uop_q, b_uop_d;
  logic [15:0]       stall_cnt_q, stall_cnt_d;

  logic b_adv, a_adv, accept, b_show;

  // Tag 0 is the hardwired zero register: it never reads the PRF and never bypasses.
  function automatic logic [XLEN-1:0] src_val(input logic [PREG_W-1:0] tag,
                                              input logic [XLEN-1:0]   prf_data,
                                              input logic              wb_v,
                                              input logic [PREG_W-1:0] wb_t,
                                              input logic [XLEN-1:0]   wb_d);
    if (tag == '0)
      return '0;
    else if (wb_v && (wb_t == tag))
      return wb_d;
    else
      return prf_data;
  endfunction

  always_comb begin
    b_adv      = !b_valid_q || out_ready_i;
    a_adv      = a_valid_q && b_adv;
    in_ready_o = (!a_valid_q || b_adv) && !recover_i;
    accept     = in_valid_i && in_ready_o;

    a_valid_d = a_valid_q;
    a_pd_d    = a_pd_q;
    a_ps1_d   = a_ps1_q;
    a_ps2_d   = a_ps2_q;
    a_uop_d   = a_uop_q;
    if (accept) begin
      a_valid_d = 1'b1;
      a_pd_d    = in_pd_tag_i;
      a_ps1_d   = in_ps1_tag_i;
      a_ps2_d   = in_ps2_tag_i;
      a_uop_d   = in_uop_i;
    end else if (a_adv) begin
      a_valid_d = 1'b0;
    end

    b_valid_d = b_valid_q;
    b_pd_d    = b_pd_q;
    b_rs1_d   = b_rs1_q;
    b_rs2_d   = b_rs2_q;
    b_uop_d   = b_uop_q;
    if (a_adv) begin
      b_valid_d = 1'b1;
      b_pd_d    = a_pd_q;
      b_rs1_d   = src_val(a_ps1_q, prf_rd1_data_i, wb_valid_i, wb_tag_i, wb_data_i);
      b_rs2_d   = src_val(a_ps2_q, prf_rd2_data_i, wb_valid_i, wb_tag_i, wb_data_i);
      b_uop_d   = a_uop_q;
    end else if (out_ready_i) begin
      b_valid_d = 1'b0;
    end

    // A flush discards both entries regardless of any handshake this cycle.
    if (recover_i) begin
      a_valid_d = 1'b0;
      b_valid_d = 1'b0;
    end

    stall_cnt_d = stall_cnt_q;
    if (out_valid_o && !out_ready_i && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_valid_q   <= 1'b0;
      a_pd_q      <= '0;
      a_ps1_q     <= '0;
      a_ps2_q     <= '0;
      a_uop_q     <= '0;
      b_valid_q   <= 1'b0;
      b_pd_q      <= '0;
      b_rs1_q     <= '0;
      b_rs2_q     <= '0;
      b_uop_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      a_valid_q   <= a_valid_d;
      a_pd_q      <= a_pd_d;
      a_ps1_q     <= a_ps1_d;
      a_ps2_q     <= a_ps2_d;
      a_uop_q     <= a_uop_d;
      b_valid_q   <= b_valid_d;
      b_pd_q      <= b_pd_d;
      b_rs1_q     <= b_rs1_d;
      b_rs2_q     <= b_rs2_d;
      b_uop_q     <= b_uop_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Outputs are forced quiet while reset is held so downstream never sees stale entries.
  always_comb begin
    b_show         = b_valid_q && !rst_i;
    out_valid_o    = b_show && !recover_i;
    out_pd_tag_o   = b_show ? b_pd_q  : '0;
    out_rs1_val_o  = b_show ? b_rs1_q : '0;
    out_rs2_val_o  = b_show ? b_rs2_q : '0;
    out_uop_o      = b_show ? b_uop_q : '0;
    prf_rd1_addr_o = rst_i ? '0 : a_ps1_q;
    prf_rd2_addr_o = rst_i ? '0 : a_ps2_q;
    stall_cnt_o    = stall_cnt_q;
  end

endmodule

// File: doc/issue_read_stage.md
ISSUE_READ_STAGE -- requirements
Module: issue_read_stage

Interface
REQ-001 SHALL have parameter PREG_W, default 7, physical register tag width.
REQ-002 SHALL have parameter XLEN, default 32, operand data width.
REQ-003 SHALL have parameter UOP_W, default 32, opaque micro-op payload width (op, imm, ROB index), passed through unmodified.
REQ-004 SHALL have ports:
- clk_i  in  1  single clock, all state on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- recover_i  in  1  mispredict flush.
- in_valid_i  in  1  issued micro-op valid, from the reservation station issue port.
- in_ready_o  out  1  stage can accept.
- in_pd_tag_i  in  PREG_W  destination tag.
- in_ps1_tag_i  in  PREG_W  source 1 tag.
- in_ps2_tag_i  in  PREG_W  source 2 tag.
- in_uop_i  in  UOP_W  payload.
- prf_rd1_addr_o  out  PREG_W  PRF read port 1 address.
- prf_rd1_data_i  in  XLEN  PRF read port 1 data, combinational.
- prf_rd2_addr_o  out  PREG_W  PRF read port 2 address.
- prf_rd2_data_i  in  XLEN  PRF read port 2 data, combinational.
- wb_valid_i  in  1  PRF writeback this cycle.
- wb_tag_i  in  PREG_W  writeback tag.
- wb_data_i  in  XLEN  writeback data.
- out_valid_o  out  1  operands ready for the functional unit.
- out_ready_i  in  1  functional unit accepts.
- out_pd_tag_o  out  PREG_W  destination tag.
- out_rs1_val_o  out  XLEN  source 1 value.
- out_rs2_val_o  out  XLEN  source 2 value.
- out_uop_o  out  UOP_W  payload.
- stall_cnt_o  out  16  saturating count of output-stall cycles.

Function
REQ-005 SHALL be a two-register pipeline:
- Stage A latches tags and payload.
- Stage B latches tags, read values and payload.
REQ-006 SHALL give an accepted micro-op a latency of 2 cycles: accepted at edge N, out_valid_o high after edge N+1 if no stall.
REQ-007 SHALL define b_adv = !b_valid || out_ready_i and a_adv = a_valid && b_adv.
REQ-008 SHALL drive in_ready_o = (!a_valid || b_adv) && !recover_i, combinationally.
REQ-009 SHALL load stage A on in_valid_i && in_ready_o; otherwise SHALL clear a_valid when a_adv, and otherwise hold stage A.
REQ-010 SHALL drive prf_rd1_addr_o/prf_rd2_addr_o from stage A ps1/ps2 tags every cycle, including while stalled.
REQ-011 SHALL, on a_adv, capture the source 1 value into stage B with this priority:
- ps1 tag == 0 gives 0.
- Otherwise, wb_valid_i && wb_tag_i == ps1 tag gives wb_data_i.
- Otherwise, prf_rd1_data_i.
REQ-012 SHALL apply the identical rule to source 2.
REQ-013 SHALL set b_valid on a_adv, clear it on out_ready_i without a_adv, and otherwise hold stage B contents stable.
REQ-014 SHALL drive out_valid_o = b_valid && !recover_i; out_* data SHALL be 0 when b_valid is 0.
REQ-015 SHALL support simultaneous accept-into-A and A-to-B transfer in one cycle (full throughput, 1 op/cycle).
REQ-016 SHALL, on recover_i, clear a_valid and b_valid at the next edge, discarding both entries; an in_valid_i in the same cycle SHALL NOT be accepted.
REQ-017 SHALL increment stall_cnt_o in every cycle with out_valid_o && !out_ready_i, saturating at 0xFFFF; recover_i SHALL NOT clear it.
REQ-018 SHALL NOT bypass a writeback whose tag is 0.

Reset
REQ-019 SHALL, on rst_i high at a rising edge, clear:
- a_valid, b_valid and stall_cnt_o to 0.
- All stage A and stage B registers to 0.
REQ-020 SHALL, during reset and the cycle after, drive out_valid_o=0, all out_* data=0 and prf_rd*_addr_o=0; in_ready_o SHALL be 1 after reset when recover_i=0.
REQ-021 SHALL, when rst_i is asserted mid-operation, discard in-flight ops identically to REQ-019, with rst_i taking priority over recover_i and the handshakes.

Verification
REQ-022 SHALL cover basic read: PRF[5]=0x11, PRF[9]=0x22, op ps1=5 ps2=9 pd=12, out_ready_i=1 -> 2 cycles later out_valid_o=1, rs1=0x11, rs2=0x22, pd=12.
REQ-023 SHALL cover bypass: op ps1=7 in stage A, wb_valid_i=1 wb_tag_i=7 wb_data_i=0xDEAD with PRF[7] stale=0 -> out_rs1_val_o=0xDEAD.
REQ-024 SHALL cover backpressure: 3 back-to-back ops with out_ready_i=0 for 4 cycles ->
- in_ready_o=0 after 2 accepted.
- Outputs held stable.
- stall_cnt_o=4.
- Then ops emerge in order with no loss or duplication.
REQ-025 SHALL cover tag-0 source: ps2=0 with PRF[0]=0xFFFF forced, wb_tag_i=0 -> out_rs2_val_o=0.
REQ-026 SHALL cover flush: both stages full, recover_i=1 for 1 cycle with in_valid_i=1 -> next cycle out_valid_o=0, nothing accepted, stall_cnt_o unchanged.
REQ-027 SHALL cover reset mid-stall: stall_cnt_o=3 with both stages full, rst_i=1 -> after edge out_valid_o=0, stall_cnt_o=0, in_ready_o=1.
